// File: rtl/vga_rom_arbiter.sv
// Two-port read arbiter in front of the shared synchronous image ROM on the 40 MHz VGA clock.
// Define VGA_ROM_ARB_REGOUT_EN to register Rom_data before Rdata0/Rdata1 (one extra cycle of latency).
module vga_rom_arbiter #(
  parameter int AW         = 11,
  parameter int DW         = 256,
  parameter int ROM_LAT    = 1,
  parameter int STARVE_MAX = 255
) (
  input  logic          CLK_40M,
  input  logic          RST,
  input  logic          Active_sig,
  input  logic          Req0,
  input  logic          Req1,
  input  logic [AW-1:0] Addr0,
  input  logic [AW-1:0] Addr1,
  output logic          Ack0,
  output logic          Ack1,
  output logic [DW-1:0] Rdata0,
  output logic [DW-1:0] Rdata1,
  output logic          Rvalid0,
  output logic          Rvalid1,
  output logic [AW-1:0] Rom_add,
  input  logic [DW-1:0] Rom_data,
  output logic [7:0]    Starve_cnt
);

`ifdef VGA_ROM_ARB_REGOUT_EN
  localparam int PIPE_D = ROM_LAT + 1;
`else
  localparam int PIPE_D = ROM_LAT;
`endif

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

  port_e      rr_last;
  logic [1:0] tag_pipe [PIPE_D];
  logic [1:0] tag_out;
  logic       accept;

  // NOTE: both outputs get a default first, so no path through this block can infer a latch.
  always_comb begin
    Ack0 = 1'b0;
    Ack1 = 1'b0;
    if (Active_sig) begin
      Ack0 = Req0;
      Ack1 = Req1 & ~Req0;
    end else if (Req0 && Req1) begin
      Ack0 = (rr_last == PORT1);
      Ack1 = (rr_last == PORT0);
    end else begin
      Ack0 = Req0;
      Ack1 = Req1;
    end
  end

  assign accept  = Ack0 | Ack1;
  assign tag_out = tag_pipe[PIPE_D-1];

  // NOTE: registers use non-blocking assignments so every stage samples its pre-edge neighbour.
  always_ff @(posedge CLK_40M) begin
    if (RST) begin
      rr_last    <= PORT1;
      Rom_add    <= '0;
      Rvalid0    <= 1'b0;
      Rvalid1    <= 1'b0;
      Starve_cnt <= '0;
      // NOTE: the tag pipe is reset (unlike a data store) since a stale tag would fire a phantom Rvalid.
      for (int i = 0; i < PIPE_D; i++) tag_pipe[i] <= 2'b00;
    end else begin
      if (accept) begin
        Rom_add <= Ack1 ? Addr1 : Addr0;
        rr_last <= Ack1 ? PORT1 : PORT0;
      end
      tag_pipe[0] <= {Ack1, Ack0};
      for (int i = 1; i < PIPE_D; i++) tag_pipe[i] <= tag_pipe[i-1];
      Rvalid0 <= tag_out[0];
      Rvalid1 <= tag_out[1];
      if (Req1 && !Ack1) begin
        if (Starve_cnt < 8'(STARVE_MAX)) Starve_cnt <= Starve_cnt + 8'd1;
      end else begin
        Starve_cnt <= '0;
      end
    end
  end

`ifdef VGA_ROM_ARB_REGOUT_EN
  logic [DW-1:0] rdata_q;

  // Capture only when a tag exits, so the word holds between responses.
  always_ff @(posedge CLK_40M) begin
    if (RST) begin
      rdata_q <= '0;
    end else if (tag_out != 2'b00) begin
      rdata_q <= Rom_data;
    end
  end

  assign Rdata0 = rdata_q;
  assign Rdata1 = rdata_q;
`else
  assign Rdata0 = Rom_data;
  assign Rdata1 = Rom_data;
`endif

endmodule

// File: doc/vga_rom_arbiter.md
# vga_rom_arbiter

Shares the single synchronous image ROM (11-bit address, 256-bit word) between two read requesters on the 40 MHz VGA clock. Port 0 is the display renderer, port 1 is a secondary client (sprite/text prefetch). The block sits between the VGA control logic and the ROM instance, drives the ROM address, and routes each returned word to the port that issued it. It gives port 0 strict priority during active video and alternates fairly during blanking.

## Interface
Parameters:
- AW, 11: ROM address width.
- DW, 256: ROM data width.
- ROM_LAT, 1: ROM read latency in cycles, from address registered to `Rom_data` valid; range 1–3.
- STARVE_MAX, 255: saturation value of the port-1 wait counter.

Ports:
- CLK_40M  in  1  — the block's only clock.
- RST  in  1  — reset, synchronous, active-high.
- Active_sig  in  1  — 1 while the display is in the visible region (fixed-priority mode).
- Req0 / Req1  in  1  — read request (valid), held until accepted.
- Addr0 / Addr1  in  AW  — read address; stable while ReqN is high.
- Ack0 / Ack1  out  1  — combinational accept; transfer when ReqN and AckN are both high at a rising edge.
- Rdata0 / Rdata1  out  DW  — returned word.
- Rvalid0 / Rvalid1  out  1  — one-cycle pulse; RdataN is valid in that cycle.
- Rom_add  out  AW  — registered ROM address.
- Rom_data  in  DW  — ROM read data.
- Starve_cnt  out  8  — consecutive cycles with Req1 high and Ack1 low, saturating at STARVE_MAX.

## Operation
- At most one grant per cycle. Ack0 and Ack1 are never high together.
- Active_sig=1: strict priority. Ack0=Req0 and Ack1=Req1&~Req0.
- Active_sig=0: round-robin.
  - A lone requester is always granted.
  - If both request, the port not granted last wins.
  - Last-grant pointer `rr_last` updates on every accepted transfer in either mode.
- On accept:
  - Rom_add <= AddrN.
  - A one-hot tag for port N enters a shift pipeline of depth ROM_LAT.
- Return path:
  - When a tag exits the pipeline, RvalidN pulses for that port.
  - Rdata0 and Rdata1 both carry Rom_data; only the tagged port's Rvalid is asserted.
- No accept in a cycle: Rom_add holds its value and a zero tag enters the pipeline.
- Responses return in issue order. Full throughput is one read per cycle, with no bubbles between back-to-back grants.
- Starve_cnt:
  - Increments when Req1=1 and Ack1=0; holds at STARVE_MAX.
  - Clears to 0 on Ack1=1 or when Req1=0.
- Reset values: Rom_add=0, tag pipeline all-zero, Rvalid0=Rvalid1=0, Starve_cnt=0, rr_last=port 1 (so port 0 wins the first tie).
- AckN stays combinational during reset. Transfers accepted while RST=1 are discarded (the pipeline is held at zero).
- Reset mid-operation: in-flight reads are dropped, and no Rvalid pulse appears for them after RST deasserts.
- Active_sig toggling with both ports requesting: the mode used is the Active_sig value in the decision cycle; no hysteresis.

## Timing
- Accept in cycle t → Rom_add valid in t+1 → Rvalid/Rdata in t+1+ROM_LAT (t+2 at the default setting).
- Ack has a combinational path from ReqN and Active_sig only. There is no path from Rom_data.
- Rvalid is registered, with no combinational path from inputs.

## Configuration
- Macro: VGA_ROM_ARB_REGOUT_EN.
- Defined:
  - Rom_data is captured in an output register before RdataN.
  - The tag pipeline is one stage deeper.
  - Latency is t+2+ROM_LAT.
  - RdataN holds the last returned word between Rvalid pulses. Reset value is 0.
- Undefined: RdataN is a direct wire from Rom_data, with the latency given under Timing.

## Test plan
- Reset check: RST high 3 cycles, then low with no requests → Rom_add=0, Rvalid0=Rvalid1=0, Starve_cnt=0 for 10 cycles.
- Active priority: Active_sig=1, Req0 and Req1 high continuously, Addr0=0x010, Addr1=0x7FF for 300 cycles.
  - Port 0 only: Ack1=0 throughout.
  - Starve_cnt reaches 255 and holds.
  - Rvalid0 every cycle from t+2 with data = ROM[0x010].
- Blanking round-robin: Active_sig=0, both requesting for 6 cycles.
  - Grants alternate 0,1,0,1,0,1.
  - Rvalid pattern is the same sequence delayed by ROM_LAT+1.
  - Starve_cnt never exceeds 1.
- Back-to-back reads: port 1 alone, addresses 5,6,7 on consecutive accepts.
  - Rom_add=5,6,7 on consecutive cycles.
  - Rvalid1 three consecutive cycles with ROM[5..7].
  - No Rvalid0.
- Reset mid-flight: accept port 0 read, assert RST the next cycle for 1 cycle → no Rvalid0 pulse afterwards.
- VGA_ROM_ARB_REGOUT_EN defined, single port-0 read of 0x020 at cycle t:
  - Rvalid0 at t+3.
  - Rdata0 = ROM[0x020], held stable until the next response.
